// File: rtl/regfile_mp_if.sv
// Decode-stage register file bus: read ports, two write ports and the
// pending-load scoreboard set request. Clock and reset stay outside.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wa_en;
    logic [ADDR_W-1:0]        wa_addr;
    logic [DATA_W-1:0]        wa_data;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     sb_set;
    logic [ADDR_W-1:0]        sb_addr;
    logic                     any_busy;

    // Decode / writeback side
    modport master (
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               sb_set, sb_addr,
        input  rd_data, rd_busy, any_busy
    );

    // Register file side
    modport slave (
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               sb_set, sb_addr,
        output rd_data, rd_busy, any_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports (A: ALU/link, B: load),
// combinational write-through bypass and a per-register pending-load
// scoreboard that flags operands decode must stall on.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic          clock,
    input  logic          reset,
    regfile_mp_if.slave   rf
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic wa_ok;
    logic wb_ok;
    logic sb_ok;

    // Qualify each request: with a hardwired zero register, anything aimed
    // at address 0 is dropped.
    always_comb begin
        wa_ok = rf.wa_en  && !(ZR && (rf.wa_addr == '0));
        wb_ok = rf.wb_en  && !(ZR && (rf.wb_addr == '0));
        sb_ok = rf.sb_set && !(ZR && (rf.sb_addr == '0));
    end

    // Register array: port A is applied after port B so the younger
    // instruction's result wins on a same-address conflict.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= '0;
            end
        end else begin
            if (wb_ok) begin
                regs[rf.wb_addr] <= rf.wb_data;
            end
            if (wa_ok) begin
                regs[rf.wa_addr] <= rf.wa_data;
            end
        end
    end

    // Pending-load scoreboard: a completing load clears its bit, a newly
    // issued load sets it; set is applied last so a new load replaces the
    // one finishing in the same cycle. Port A never touches these bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            if (wb_ok) begin
                busy[rf.wb_addr] <= 1'b0;
            end
            if (sb_ok) begin
                busy[rf.sb_addr] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              zero_hit;
        logic              a_hit;
        logic              b_hit;

        assign addr     = rf.rd_addr[i*ADDR_W +: ADDR_W];
        assign zero_hit = ZR && (addr == '0);
        assign a_hit    = rf.wa_en && (rf.wa_addr == addr);
        assign b_hit    = rf.wb_en && (rf.wb_addr == addr);

        // Bypass priority: zero register, then port A, then port B, then array.
        assign rf.rd_data[i*DATA_W +: DATA_W] =
            zero_hit ? '0         :
            a_hit    ? rf.wa_data :
            b_hit    ? rf.wb_data :
                       regs[addr];

        // A load completing this cycle satisfies the pending operand.
        assign rf.rd_busy[i] = busy[addr] && !b_hit && !zero_hit;
    end

    assign rf.any_busy = |rf.rd_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: stimulus pushes hand-computed expectations
// into a queue, an independent monitor pops one per cycle and compares.
module tb_regfile_mp;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic clock;
    logic reset;

    regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

    regfile_mp #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .rf    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [8*10-1:0] tag;
        logic [31:0]     d0;
        logic [31:0]     d1;
        logic [1:0]      bsy;
        logic            any;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input logic [8*10-1:0] tag, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %0s.%0s actual=%h required=%h", tag, field, act, req);
        end
    endtask

    // Monitor: outputs are combinational, so one expectation is due per
    // cycle and is sampled on the falling edge, away from the write edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.tag, "d0",   bus.rd_data[31:0],  e.d0);
                cmp(e.tag, "d1",   bus.rd_data[63:32], e.d1);
                cmp(e.tag, "busy", {30'd0, bus.rd_busy}, {30'd0, e.bsy});
                cmp(e.tag, "any",  {31'd0, bus.any_busy}, {31'd0, e.any});
            end
        end
    end

    task automatic drive(input logic [4:0] r0, input logic [4:0] r1,
                         input logic wae, input logic [4:0] waa, input logic [31:0] wad,
                         input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                         input logic sbs, input logic [4:0] sba);
        bus.rd_addr = {r1, r0};
        bus.wa_en   = wae;  bus.wa_addr = waa;  bus.wa_data = wad;
        bus.wb_en   = wbe;  bus.wb_addr = wba;  bus.wb_data = wbd;
        bus.sb_set  = sbs;  bus.sb_addr = sba;
    endtask

    task automatic expect_out(input logic [8*10-1:0] tag, input logic [31:0] d0,
                              input logic [31:0] d1, input logic [1:0] bsy);
        exp_t e;
        e.tag = tag; e.d0 = d0; e.d1 = d1; e.bsy = bsy; e.any = |bsy;
        q.push_back(e);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int w;
        reset = 1'b0;
        drive(5'd5, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held: everything reads zero; port A still bypasses
        step(); expect_out("rst_rd",   32'h0, 32'h0, 2'b00);
        step(); drive(5'd5, 5'd3, 1, 5'd5, 32'h77, 0, 0, 0, 0, 0);
                expect_out("rst_byp",  32'h77, 32'h0, 2'b00);
        step(); drive(5'd5, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0);
                expect_out("rst_nowr", 32'h0, 32'h0, 2'b00);

        // Release reset and write r3
        step(); reset = 1'b1;
                drive(5'd3, 5'd5, 1, 5'd3, 32'h1234, 0, 0, 0, 0, 0);
                expect_out("wr_byp",   32'h1234, 32'h0, 2'b00);
        step(); drive(5'd3, 5'd5, 0, 0, 0, 0, 0, 0, 0, 0);
                expect_out("wr_store", 32'h1234, 32'h0, 2'b00);

        // Zero register on all ports
        step(); drive(5'd0, 5'd0, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'h5, 1, 5'd0);
                expect_out("zero_now", 32'h0, 32'h0, 2'b00);
        step(); drive(5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
                expect_out("zero_aft", 32'h0, 32'h0, 2'b00);

        // Dual-write conflict on r7: port A wins
        step(); drive(5'd7, 5'd3, 1, 5'd7, 32'hA, 1, 5'd7, 32'hB, 0, 0);
                expect_out("conf_now", 32'hA, 32'h1234, 2'b00);
        step(); drive(5'd7, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0);
                expect_out("conf_aft", 32'hA, 32'h1234, 2'b00);

        // Load scoreboard on r9
        step(); drive(5'd9, 5'd7, 0, 0, 0, 0, 0, 0, 1, 5'd9);
                expect_out("sb_c1",    32'h0, 32'hA, 2'b00);
        step(); drive(5'd9, 5'd7, 0, 0, 0, 0, 0, 0, 0, 0);
                expect_out("sb_c2",    32'h0, 32'hA, 2'b01);
        step(); drive(5'd7, 5'd9, 0, 0, 0, 0, 0, 0, 0, 0);
                expect_out("sb_c3",    32'hA, 32'h0, 2'b10);
        step(); drive(5'd9, 5'd9, 0, 0, 0, 1, 5'd9, 32'h55, 0, 0);
                expect_out("sb_c4",    32'h55, 32'h55, 2'b00);
        step(); drive(5'd9, 5'd9, 0, 0, 0, 0, 0, 0, 0, 0);
                expect_out("sb_c5",    32'h55, 32'h55, 2'b00);

        // Set/clear collision on r9: data stored, set wins
        step(); drive(5'd9, 5'd9, 0, 0, 0, 1, 5'd9, 32'h66, 1, 5'd9);
                expect_out("coll_now", 32'h66, 32'h66, 2'b00);
        step(); drive(5'd9, 5'd9, 0, 0, 0, 0, 0, 0, 0, 0);
                expect_out("coll_aft", 32'h66, 32'h66, 2'b11);

        // Port A write leaves the busy bit alone
        step(); drive(5'd9, 5'd9, 1, 5'd9, 32'h70, 0, 0, 0, 0, 0);
                expect_out("wa_busy",  32'h70, 32'h70, 2'b11);
        step(); drive(5'd9, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0);
                expect_out("pre_arst", 32'h70, 32'h1234, 2'b01);

        // Async reset between edges
        step(); drive(5'd9, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0);
                #2 reset = 1'b0;
                expect_out("arst",     32'h0, 32'h0, 2'b00);
        step(); reset = 1'b1;
                expect_out("post_rst", 32'h0, 32'h0, 2'b00);

        // Drain the scoreboard with a bounded wait
        w = 0;
        while (q.size() > 0 && w < 20) begin
            @(negedge clock);
            w++;
        end
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
